// File: rtl/prod_accum_pkg.sv
// Shared constants and FSM state encoding for the product accumulator.
package prod_accum_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAccWidth  = 40;
    localparam int unsigned DefCntWidth  = 8;

    // Encoding 2'd3 is unused; the FSM recovers from it to StIdle.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/prod_accum_if.sv
// Job control, product stream and result handshake of the product accumulator.
interface prod_accum_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ACCWIDTH  = 40,
    parameter int unsigned CNTWIDTH  = 8
);

    logic                 start;
    logic [CNTWIDTH-1:0]  len;
    logic [DATAWIDTH-1:0] prod;
    logic                 prod_valid;
    logic                 prod_ready;
    logic [ACCWIDTH-1:0]  sum;
    logic                 sum_valid;
    logic                 sum_ready;
    logic                 busy;
    logic                 ovf;

    modport master (
        output start, len, prod, prod_valid, sum_ready,
        input  prod_ready, sum, sum_valid, busy, ovf
    );

    modport slave (
        input  start, len, prod, prod_valid, sum_ready,
        output prod_ready, sum, sum_valid, busy, ovf
    );

endinterface

// File: rtl/prod_accum_beat_counter.sv
// Counts accepted beats of a job against the job length latched at start.
module prod_accum_beat_counter #(
    parameter int unsigned CNTWIDTH = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                load_i,
    input  logic [CNTWIDTH-1:0] len_i,
    input  logic                inc_i,
    output logic                last_o
);

    logic [CNTWIDTH-1:0] count_d, count_q;
    logic [CNTWIDTH-1:0] len_d, len_q;

    always_comb begin
        count_d = count_q;
        len_d   = len_q;
        if (load_i) begin
            len_d   = len_i;
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNTWIDTH'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
            len_q   <= '0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign last_o = (count_q == len_q - CNTWIDTH'(1));

endmodule

// File: rtl/prod_accum.sv
// Accumulates 'len' multiplier products per job and presents the registered total.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DefDataWidth,
    parameter int unsigned ACCWIDTH  = DefAccWidth,
    parameter int unsigned CNTWIDTH  = DefCntWidth
) (
    input logic         Clk,
    input logic         Rst_n,
    prod_accum_if.slave bus
);

    state_e              state_d, state_q;
    logic [ACCWIDTH-1:0] acc_d, acc_q;
    logic                ovf_d, ovf_q;

    logic                beat;
    logic                load;
    logic                last;
    logic [ACCWIDTH-1:0] acc_sum;
    logic                carry;

    assign beat = bus.prod_valid && (state_q == StAccum);
    assign load = (state_q == StIdle) && bus.start && (bus.len != '0);

    assign {carry, acc_sum} = {1'b0, acc_q} + (ACCWIDTH + 1)'(bus.prod);

    prod_accum_beat_counter #(
        .CNTWIDTH (CNTWIDTH)
    ) u_beat_counter (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .load_i (load),
        .len_i  (bus.len),
        .inc_i  (beat),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.len != '0) ? StAccum : StDone;
                end
            end
            StAccum: begin
                if (beat) begin
                    acc_d = acc_sum;
                    ovf_d = ovf_q | carry;
                    if (last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.sum_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode only from registered state: no prod_valid -> prod_ready path.
    assign bus.prod_ready = (state_q == StAccum);
    assign bus.sum_valid  = (state_q == StDone);
    assign bus.busy       = (state_q == StAccum) || (state_q == StDone);
    assign bus.sum        = acc_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed scoreboard bench for prod_accum: a 32/40-bit instance and an 8/8-bit wrap instance.
module tb_prod_accum;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b1;

    always #5 Clk = ~Clk;

    prod_accum_if #(.DATAWIDTH(32), .ACCWIDTH(40), .CNTWIDTH(8)) bus_a ();
    prod_accum_if #(.DATAWIDTH(8),  .ACCWIDTH(8),  .CNTWIDTH(8)) bus_b ();

    prod_accum #(
        .DATAWIDTH (32),
        .ACCWIDTH  (40),
        .CNTWIDTH  (8)
    ) u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_a)
    );

    prod_accum #(
        .DATAWIDTH (8),
        .ACCWIDTH  (8),
        .CNTWIDTH  (8)
    ) u_small (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_b)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [40:0] sb[$];   // {ovf, sum}
    logic [31:0] pv[8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Runs one job on the wide instance; gaps alternates prod_valid, hold stalls sum_ready.
    task automatic run_main(input int n, input bit gaps, input int hold);
        logic [63:0] tot;
        logic [40:0] e;
        int          idx;
        int          cyc;
        bit          took;
        tot = '0;
        idx = 0;
        cyc = 0;
        for (int i = 0; i < n; i++) tot += 64'(pv[i]);
        sb.push_back({(tot >= 64'h100_0000_0000), tot[39:0]});
        bus_a.start     = 1'b1;
        bus_a.len       = 8'(n);
        bus_a.sum_ready = gaps;
        step();
        bus_a.start = 1'b0;
        bus_a.len   = 8'hff;
        while (idx < n && cyc < 64) begin
            bus_a.prod_valid = !gaps || (cyc % 2 == 0);
            bus_a.prod       = bus_a.prod_valid ? pv[idx] : 32'hdead_beef;
            check("prod_ready_accum", bus_a.prod_ready, 1);
            check("no_early_valid", bus_a.sum_valid, 0);
            took = bus_a.prod_valid && bus_a.prod_ready;
            step();
            if (took) idx++;
            cyc++;
        end
        bus_a.prod_valid = 1'b0;
        if (idx != n) check("beat_timeout", 64'(idx), 64'(n));
        check("sum_valid_rise", bus_a.sum_valid, 1);
        check("prod_ready_done", bus_a.prod_ready, 0);
        e = sb.pop_front();
        check("sum", bus_a.sum, 64'(e[39:0]));
        check("ovf", bus_a.ovf, 64'(e[40]));
        for (int h = 0; h < hold; h++) begin
            bus_a.sum_ready = 1'b0;
            bus_a.start     = 1'b1;
            bus_a.len       = 8'd5;
            step();
            check("hold_valid", bus_a.sum_valid, 1);
            check("hold_sum", bus_a.sum, 64'(e[39:0]));
            check("hold_ready", bus_a.prod_ready, 0);
        end
        bus_a.start     = 1'b0;
        bus_a.sum_ready = 1'b1;
        step();
        bus_a.sum_ready = 1'b0;
        check("back_idle_valid", bus_a.sum_valid, 0);
        check("back_idle_busy", bus_a.busy, 0);
        check("sum_kept", bus_a.sum, 64'(e[39:0]));
    endtask

    task automatic run_small(input int n, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] tot;
        logic [40:0] e;
        tot = 16'(a) + ((n > 1) ? 16'(b) : 16'd0);
        sb.push_back({(tot > 16'd255), 32'd0, tot[7:0]});
        bus_b.start = 1'b1;
        bus_b.len   = 8'(n);
        step();
        bus_b.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_b.prod_valid = 1'b1;
            bus_b.prod       = (i == 0) ? a : b;
            check("small_prod_ready", bus_b.prod_ready, 1);
            step();
        end
        bus_b.prod_valid = 1'b0;
        check("small_sum_valid", bus_b.sum_valid, 1);
        e = sb.pop_front();
        check("small_sum", bus_b.sum, 64'(e[7:0]));
        check("small_ovf", bus_b.ovf, 64'(e[40]));
        bus_b.sum_ready = 1'b1;
        step();
        bus_b.sum_ready = 1'b0;
        check("small_idle", bus_b.busy, 0);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.len = '0; bus_a.prod = '0;
        bus_a.prod_valid = 1'b0; bus_a.sum_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.len = '0; bus_b.prod = '0;
        bus_b.prod_valid = 1'b0; bus_b.sum_ready = 1'b0;
        #2 Rst_n = 1'b0;
        step();
        step();
        check("rst_sum", bus_a.sum, 0);
        check("rst_sum_valid", bus_a.sum_valid, 0);
        check("rst_prod_ready", bus_a.prod_ready, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_ovf", bus_a.ovf, 0);
        Rst_n = 1'b1;
        step();

        // Continuous beats, then the same job with valid gaps and sum_ready high early.
        pv[0] = 32'd5; pv[1] = 32'd7; pv[2] = 32'd9;
        run_main(3, 1'b0, 0);
        run_main(3, 1'b1, 0);

        // Stalled consumer with start pulses ignored in DONE.
        pv[0] = 32'd100; pv[1] = 32'd200; pv[2] = 32'd300; pv[3] = 32'd400;
        run_main(4, 1'b0, 5);

        // Carry into the upper accumulator bits.
        pv[0] = 32'hffff_ffff; pv[1] = 32'hffff_ffff; pv[2] = 32'hffff_ffff;
        run_main(3, 1'b0, 0);

        // Empty job.
        run_main(0, 1'b0, 0);

        // Narrow instance: wrap sets ovf, next job clears it.
        run_small(2, 8'd200, 8'd100);
        run_small(1, 8'd3, 8'd0);

        // Asynchronous reset in the middle of a job.
        bus_a.start = 1'b1;
        bus_a.len   = 8'd4;
        step();
        bus_a.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_a.prod_valid = 1'b1;
            bus_a.prod       = 32'(i + 1);
            step();
        end
        check("pre_reset_sum", bus_a.sum, 3);
        check("pre_reset_busy", bus_a.busy, 1);
        Rst_n = 1'b0;
        #1;
        check("async_sum", bus_a.sum, 0);
        check("async_busy", bus_a.busy, 0);
        check("async_prod_ready", bus_a.prod_ready, 0);
        check("async_sum_valid", bus_a.sum_valid, 0);
        check("async_ovf", bus_a.ovf, 0);
        bus_a.prod_valid = 1'b0;
        step();
        Rst_n = 1'b1;
        step();
        pv[0] = 32'd11; pv[1] = 32'd22;
        run_main(2, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
